dense_layer: RTL and testbench
==============================

DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every signed fixed-point word.
REQ-002 Parameter FRAC_BITS, default 7: fractional bits of the Q format.
REQ-003 Parameter IN_DIM, default 1568: input vector length.
REQ-004 Parameter OUT_DIM, default 10: output vector length.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 start  in  1  single-cycle request to compute; sampled only in IDLE.
REQ-008 in_vec  in  IN_DIM x DATA_WIDTH signed  input activations.
REQ-009 weights  in  OUT_DIM x IN_DIM x DATA_WIDTH signed  weight matrix [out][in].
REQ-010 biases  in  OUT_DIM x DATA_WIDTH signed  biases, same Q format.
REQ-011 out_vec  out  OUT_DIM x DATA_WIDTH signed  registered results.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high from the start-accept edge until the done edge.

Function
REQ-014 out_vec[o] SHALL equal sat( (sum_i in_vec[i]*weights[o][i]) >>> FRAC_BITS + biases[o] ).
REQ-015 Products full 2*DATA_WIDTH signed; accumulator 2*DATA_WIDTH+clog2(IN_DIM) bits; no intermediate overflow.
REQ-016 Shift is arithmetic (floor toward -inf, no rounding); bias sign-extended and added at accumulator width.
REQ-017 sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-018 FSM states IDLE, MAC, WRITE; IDLE->MAC on start; MAC->WRITE after index IN_DIM-1; WRITE->MAC (next o) or ->IDLE after o=OUT_DIM-1.
REQ-019 One multiply-accumulate per cycle in MAC; accumulator cleared on entry to each neuron.
REQ-020 WRITE cycle stores out_vec[o]; other out_vec entries hold value.
REQ-021 done asserted on the same edge as the final out_vec write; high exactly one cycle.
REQ-022 Latency: start sampled at edge k -> done high after edge k+OUT_DIM*(IN_DIM+1).
REQ-023 start while busy is ignored (no restart, no queueing); start coincident with done-cycle return to IDLE is accepted next cycle only.
REQ-024 in_vec, weights, biases must be held stable while busy; behaviour otherwise undefined.
REQ-025 out_vec retains last results until overwritten by a subsequent run.

Reset
REQ-026 reset low forces IDLE, indices 0, accumulator 0, done 0, busy 0, all out_vec 0, immediately (asynchronous).
REQ-027 reset asserted mid-computation aborts; no done pulse is produced for the aborted run.
REQ-028 After reset release, first start begins a fresh full computation.

Structure
REQ-029 Shared package holds Q-format constants (DATA_WIDTH, FRAC_BITS), saturation function, and FSM state enum type.
REQ-030 One sub-module natural: mac_unit (multiply, accumulate, shift, bias add, saturate).
REQ-031 No other sub-modules; single multiplier instance.

Verification (IN_DIM=4, OUT_DIM=3, Q8.7, 1.0=0x0080)
REQ-032 in=[0x0080,0x0100,0x0180,0x0200], weights row0 all 0x0080, bias0=0 -> out_vec[0]=0x0500; done exactly 15 cycles after start edge.
REQ-033 Same inputs, row1 all 0xFF80, bias1=0x0080 -> out_vec[1]=0xFB80 (-9.0).
REQ-034 in all 0x7FFF, row2 all 0x7FFF -> out_vec[2]=0x7FFF; row all 0x8000 with in 0x7FFF -> 0x8000 (saturation both ends).
REQ-035 in=[0x0001,0,0,0], row weight 0xFFFF (-1 LSB), bias 0 -> 0xFFFF (floor); weight 0x0001 -> 0x0000.
REQ-036 Pulse start again while busy -> ignored, done still at original 15-cycle point; reset low at cycle 6 -> outputs 0, no done, then a fresh start completes normally.

Source files
------------

// File: rtl/dense_layer_pkg.sv
// Shared definitions for the dense (fully connected) layer.
//   Q_DATA_WIDTH / Q_FRAC_BITS : default fixed-point word format (Q8.7)
//   SAT_W                      : working width of the saturation helper
//   dense_state_e              : sequencer state encoding
//   sat_q()                    : clamp a wide signed value into a dw-bit signed range
package dense_layer_pkg;

    localparam int unsigned Q_DATA_WIDTH = 16;
    localparam int unsigned Q_FRAC_BITS  = 7;

    // Any accumulator up to this width can be routed through sat_q.
    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } dense_state_e;

    // Clamp x into [-2^(dw-1), 2^(dw-1)-1]; caller truncates the result to dw bits.
    function automatic logic signed [SAT_W-1:0] sat_q(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
        min_v = ~max_v;
        if (x > max_v) begin
            return max_v;
        end else if (x < min_v) begin
            return min_v;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/dense_layer_mac_unit.sv
// Multiply-accumulate datapath for one neuron at a time.
//   clk, reset : clock, async active-low reset
//   clear      : zero the accumulator (held while not accumulating)
//   en         : add a*b into the accumulator this cycle
//   a, b       : signed activation and weight operands
//   bias       : signed bias for the current neuron
//   result_c   : combinational sat((acc >>> FRAC_BITS) + bias)
module dense_layer_mac_unit
    import dense_layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = Q_FRAC_BITS,
    parameter int unsigned IN_DIM     = 1568
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] result_c
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    // Headroom of clog2(IN_DIM) bits means the full dot product can never wrap.
    localparam int unsigned ACC_W  = PROD_W + $clog2(IN_DIM);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [ACC_W-1:0]  biased_c;
    logic signed [SAT_W-1:0]  sat_c;

    // Operands sign-extended first so the product is the exact full-width value.
    assign prod_c    = PROD_W'(a) * PROD_W'(b);
    // Arithmetic shift floors toward -inf; no rounding.
    assign shifted_c = acc >>> FRAC_BITS;
    assign biased_c  = shifted_c + ACC_W'(bias);
    assign sat_c     = sat_q(SAT_W'(biased_c), DATA_WIDTH);
    assign result_c  = DATA_WIDTH'(sat_c);

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_c);
        end
    end

endmodule

// File: rtl/dense_layer.sv
// Sequential fully connected layer: out_vec[o] = sat((W[o] . in_vec) >>> FRAC_BITS + biases[o]).
// One MAC per cycle, IN_DIM MAC cycles plus one WRITE cycle per output neuron.
//   clk, reset : clock, async active-low reset
//   start      : one-cycle compute request, honoured only when idle
//   in_vec     : IN_DIM signed activations
//   weights    : OUT_DIM x IN_DIM signed weights, [out][in]
//   biases     : OUT_DIM signed biases
//   out_vec    : OUT_DIM registered results, held until the next run overwrites them
//   done       : one-cycle pulse on the edge that writes the last result
//   busy       : high from the start-accept edge until the done edge
module dense_layer
    import dense_layer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = Q_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = Q_FRAC_BITS,
    parameter int unsigned IN_DIM     = 1568,
    parameter int unsigned OUT_DIM    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_vec  [IN_DIM],
    input  logic signed [DATA_WIDTH-1:0] weights [OUT_DIM][IN_DIM],
    input  logic signed [DATA_WIDTH-1:0] biases  [OUT_DIM],
    output logic signed [DATA_WIDTH-1:0] out_vec [OUT_DIM],
    output logic                         done,
    output logic                         busy
);

    localparam int unsigned IN_IDX_W  = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
    localparam int unsigned OUT_IDX_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [IN_IDX_W-1:0]  LAST_IN  = IN_IDX_W'(IN_DIM - 1);
    localparam logic [OUT_IDX_W-1:0] LAST_OUT = OUT_IDX_W'(OUT_DIM - 1);

    dense_state_e                  state;
    logic [IN_IDX_W-1:0]           in_idx;
    logic [OUT_IDX_W-1:0]          out_idx;
    logic                          mac_en_c;
    logic                          mac_clear_c;
    logic signed [DATA_WIDTH-1:0]  mac_a_c;
    logic signed [DATA_WIDTH-1:0]  mac_b_c;
    logic signed [DATA_WIDTH-1:0]  mac_bias_c;
    logic signed [DATA_WIDTH-1:0]  mac_result_c;

    // Accumulator is only live in MAC; everywhere else it is held at zero so
    // each neuron starts from a clean sum.
    assign mac_en_c    = (state == MAC);
    assign mac_clear_c = (state != MAC);

    // Operand selection for the single shared multiplier.
    assign mac_a_c    = in_vec[in_idx];
    assign mac_b_c    = weights[out_idx][in_idx];
    assign mac_bias_c = biases[out_idx];

    dense_layer_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .IN_DIM     (IN_DIM)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (mac_clear_c),
        .en       (mac_en_c),
        .a        (mac_a_c),
        .b        (mac_b_c),
        .bias     (mac_bias_c),
        .result_c (mac_result_c)
    );

    // Sequencer: indices, result write-back, status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            in_idx  <= '0;
            out_idx <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            for (int unsigned o = 0; o < OUT_DIM; o++) begin
                out_vec[o] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= MAC;
                        in_idx  <= '0;
                        out_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                MAC: begin
                    if (in_idx == LAST_IN) begin
                        state <= WRITE;
                    end else begin
                        in_idx <= in_idx + IN_IDX_W'(1);
                    end
                end
                WRITE: begin
                    out_vec[out_idx] <= mac_result_c;
                    in_idx           <= '0;
                    if (out_idx == LAST_OUT) begin
                        state   <= IDLE;
                        out_idx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state   <= MAC;
                        out_idx <= out_idx + OUT_IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer with IN_DIM=4, OUT_DIM=3, Q8.7 (1.0 = 0x0080).
module tb_dense_layer;

    localparam int unsigned DW   = 16;
    localparam int unsigned NIN  = 4;
    localparam int unsigned NOUT = 3;
    localparam int          LAT  = NOUT * (NIN + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [DW-1:0] in_vec  [NIN];
    logic signed [DW-1:0] weights [NOUT][NIN];
    logic signed [DW-1:0] biases  [NOUT];
    logic signed [DW-1:0] out_vec [NOUT];
    logic                 done;
    logic                 busy;

    int tests;
    int failed;

    typedef struct {
        logic [15:0] in_v [NIN];
        logic [15:0] w    [NOUT][NIN];
        logic [15:0] b    [NOUT];
        logic [15:0] exp_v[NOUT];
    } vec_t;

    vec_t vecs [3];

    dense_layer #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (7),
        .IN_DIM     (NIN),
        .OUT_DIM    (NOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_vec  (in_vec),
        .weights (weights),
        .biases  (biases),
        .out_vec (out_vec),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic apply(input int v);
        for (int i = 0; i < NIN; i++) in_vec[i] = vecs[v].in_v[i];
        for (int o = 0; o < NOUT; o++) begin
            biases[o] = vecs[v].b[o];
            for (int i = 0; i < NIN; i++) weights[o][i] = vecs[v].w[o][i];
        end
    endtask

    task automatic check_outputs(input string tag, input int v);
        for (int o = 0; o < NOUT; o++) begin
            chk($sformatf("%s_out%0d", tag, o), out_vec[o], vecs[v].exp_v[o]);
        end
    endtask

    // Pulse start (sampled at edge 0), then wait for done with a bounded loop.
    // ignore_at: cycle whose edge also sees start high (should be ignored).
    // peek: after the first WRITE edge, check out_vec[0] updated and out_vec[1] held.
    task automatic run(input string tag, input int ignore_at, input bit peek,
                       input logic [15:0] peek0, input logic [15:0] peek1);
        int lat;
        lat   = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_high"}, 16'(busy), 16'h0001);
        for (int n = 1; n <= 40; n++) begin
            start = (n == ignore_at);
            @(posedge clk); #1;
            if (peek && n == int'(NIN) + 1) begin
                chk({tag, "_first_write"}, out_vec[0], peek0);
                chk({tag, "_hold_other"}, out_vec[1], peek1);
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 16'(lat), 16'(LAT));
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 16'(done), 16'h0000);
        chk({tag, "_busy_low"}, 16'(busy), 16'h0000);
    endtask

    initial begin
        int seen;
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < NIN; i++) in_vec[i] = '0;
        for (int o = 0; o < NOUT; o++) begin
            biases[o] = '0;
            for (int i = 0; i < NIN; i++) weights[o][i] = '0;
        end

        // 1.0..4.0 dotted with +1.0, -1.0 (+1.0 bias), and zero weights (+2.0 bias)
        vecs[0].in_v  = '{16'h0080, 16'h0100, 16'h0180, 16'h0200};
        vecs[0].w     = '{'{16'h0080, 16'h0080, 16'h0080, 16'h0080},
                          '{16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80},
                          '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[0].b     = '{16'h0000, 16'h0080, 16'h0100};
        vecs[0].exp_v = '{16'h0500, 16'hFB80, 16'h0100};
        // Floor on negative LSB, truncation of positive LSB, -1 LSB + 1 LSB bias
        vecs[1].in_v  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
        vecs[1].w     = '{'{16'hFFFF, 16'h0000, 16'h0000, 16'h0000},
                          '{16'h0001, 16'h0000, 16'h0000, 16'h0000},
                          '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000}};
        vecs[1].b     = '{16'h0000, 16'h0000, 16'h0001};
        vecs[1].exp_v = '{16'hFFFF, 16'h0000, 16'h0000};
        // Positive and negative saturation, and an exact max value without clamping
        vecs[2].in_v  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[2].w     = '{'{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                          '{16'h8000, 16'h8000, 16'h8000, 16'h8000},
                          '{16'h0080, 16'h0000, 16'h0000, 16'h0000}};
        vecs[2].b     = '{16'h0000, 16'h0000, 16'h0000};
        vecs[2].exp_v = '{16'h7FFF, 16'h8000, 16'h7FFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 16'(done), 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0000);
        for (int o = 0; o < NOUT; o++) chk($sformatf("reset_out%0d", o), out_vec[o], 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            apply(v);
            run($sformatf("vec%0d", v), 0, 1'b0, 16'h0000, 16'h0000);
            check_outputs($sformatf("vec%0d", v), v);
        end

        // Start re-pulsed mid-run is ignored; out_vec[1] holds 0x8000 from the previous run
        apply(0);
        run("restart_ignored", 6, 1'b1, 16'h0500, 16'h8000);
        check_outputs("restart_ignored", 0);

        // Asynchronous reset six cycles into a run aborts it without a done pulse
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("abort_done", 16'(done), 16'h0000);
        chk("abort_busy", 16'(busy), 16'h0000);
        for (int o = 0; o < NOUT; o++) chk($sformatf("abort_out%0d", o), out_vec[o], 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen  = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", 16'(seen), 16'h0000);

        // Fresh computation after the abort
        run("after_abort", 0, 1'b0, 16'h0000, 16'h0000);
        check_outputs("after_abort", 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
